onchip_stream_reader: RTL and testbench
=======================================

ONCHIP_STREAM_READER -- requirements
Module: onchip_stream_reader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning output buffer entries and maximum outstanding reads (power of 2, 2..16).
REQ-002 clk  input  1  single clock for all logic.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to begin a transfer; sampled only in IDLE.
REQ-005 base_addr  input  12  first word address, captured on accepted start.
REQ-006 length  input  13  word count 0..4096, captured on accepted start.
REQ-007 busy  output  1  high from accepted start until done pulse inclusive.
REQ-008 done  output  1  one-cycle pulse at transfer completion.
REQ-009 avm_address  output  12  Avalon-MM master word address.
REQ-010 avm_read  output  1  Avalon-MM read request.
REQ-011 avm_waitrequest  input  1  slave stall; request held while high.
REQ-012 avm_readdata  input  32  read data from slave.
REQ-013 avm_readdatavalid  input  1  qualifies avm_readdata; one per accepted read, in order.
REQ-014 src_data  output  32  Avalon-ST source data.
REQ-015 src_valid  output  1  src_data valid.
REQ-016 src_ready  input  1  sink ready, zero ready latency.
REQ-017 src_sop  output  1  high with the first word of a transfer.
REQ-018 src_eop  output  1  high with the last word of a transfer.

Function
REQ-019 FSM states IDLE, READ, DRAIN; reset state IDLE.
REQ-020 IDLE: start=1 with length>0 -> READ, capture base_addr/length, busy=1 next cycle.
REQ-021 IDLE: start=1 with length=0 -> stay IDLE, done=1 next cycle, busy high that one cycle, no bus or stream activity.
REQ-022 Read accepted when avm_read=1 and avm_waitrequest=0; address increments by 1 per accepted read, wrapping 4095 -> 0.
REQ-023 avm_read asserted in READ only when fifo_count + outstanding < FIFO_DEPTH; once asserted, avm_read and avm_address held stable until accepted.
REQ-024 outstanding counter: +1 on accepted read, -1 on avm_readdatavalid, both in same cycle -> unchanged.
REQ-025 Data with avm_readdatavalid written to FIFO the same cycle; FIFO never overflows by REQ-023 credit rule.
REQ-026 src_valid = FIFO not empty; word popped when src_valid and src_ready; simultaneous push and pop on full or empty FIFO legal, count unchanged.
REQ-027 Minimum latency avm_readdatavalid -> src_valid: 1 clock (registered FIFO output).
REQ-028 src_sop on word index 0, src_eop on word index length-1; both high for length=1.
REQ-029 READ -> DRAIN on acceptance of the length-th read.
REQ-030 DRAIN -> IDLE when eop word popped; done=1 that following cycle, busy drops with it.
REQ-031 start outside IDLE ignored.
REQ-032 avm_readdatavalid with outstanding=0 is a protocol error; data discarded, counter held at 0.

Reset
REQ-033 reset_n low: state IDLE, busy=0, done=0, avm_read=0, avm_address=0, src_valid=0, src_sop=0, src_eop=0, FIFO and counters cleared, immediately and asynchronously.
REQ-034 Reset mid-transfer aborts; late avm_readdatavalid after release handled per REQ-032.
REQ-035 Deassertion of reset_n synchronised externally; block takes no action in the release cycle beyond leaving reset.

Configuration
REQ-036 Macro ONCHIP_STREAM_READER_BYTESWAP_EN defined: src_data = avm_readdata byte-reversed ({b0,b1,b2,b3}).
REQ-037 Macro undefined: src_data = avm_readdata unchanged; all timing identical either way.

Verification
REQ-038 base=0x010, length=3, waitrequest=0, fixed read latency 1, src_ready=1 -> addresses 0x010,0x011,0x012; 3 words, sop on 1st, eop on 3rd, done 1 cycle after eop.
REQ-039 base=0xFFE, length=4 -> addresses 0xFFE,0xFFF,0x000,0x001.
REQ-040 length=8, src_ready=0 throughout, FIFO_DEPTH=4 -> exactly 4 reads accepted, then avm_read=0; raising src_ready resumes, 8 words total in order.
REQ-041 waitrequest high 3 cycles on 2nd read -> avm_address/avm_read stable those 3 cycles, no duplicate or lost word.
REQ-042 length=0 -> done pulse, no avm_read, no src_valid; length=1 -> single word with sop=eop=1.
REQ-043 reset_n low mid-transfer with 2 reads outstanding -> all outputs zero immediately; subsequent start length=2 yields exactly 2 correct words.

Source files
------------

// File: rtl/onchip_stream_reader_if.sv
// Avalon-MM read master and Avalon-ST source signals of onchip_stream_reader.
// The master modport is the reader side; the slave modport is the memory/sink side.
interface onchip_stream_reader_if;
   logic [11:0] avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;
   logic        src_sop;
   logic        src_eop;

   modport master (
      output avm_address, avm_read, src_data, src_valid, src_sop, src_eop,
      input  avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready
   );

   modport slave (
      input  avm_address, avm_read, src_data, src_valid, src_sop, src_eop,
      output avm_waitrequest, avm_readdata, avm_readdatavalid, src_ready
   );
endinterface

// File: rtl/onchip_stream_reader.sv
// Reads `length` words from an Avalon-MM slave and streams them out on Avalon-ST.
// Define ONCHIP_STREAM_READER_BYTESWAP_EN to byte-reverse each streamed word.
module onchip_stream_reader #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [11:0] base_addr,
   input  logic [12:0] length,
   output logic        busy,
   output logic        done,
   onchip_stream_reader_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]    state_reg, state_next;
   logic [11:0]   addr_reg;
   logic          rd_reg, rd_next;
   logic [12:0]   reads_left_reg, len_reg, pop_idx_reg;
   logic [CW-1:0] outs_reg, outs_next, count_reg, count_next;
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic          done_reg;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [31:0]   wdata;

   logic accept, push, pop, is_eop, start_ok, start_zero, last_read;

   assign accept     = rd_reg & ~bus.avm_waitrequest;
   // Data with no read outstanding is a protocol error and is dropped.
   assign push       = bus.avm_readdatavalid & (outs_reg != '0);
   assign pop        = (count_reg != '0) & bus.src_ready;
   assign is_eop     = (pop_idx_reg == len_reg - 13'd1);
   assign start_ok   = (state_reg == IDLE) & start & (length != 13'd0);
   assign start_zero = (state_reg == IDLE) & start & (length == 13'd0);
   assign last_read  = accept & (reads_left_reg == 13'd1);

`ifdef ONCHIP_STREAM_READER_BYTESWAP_EN
   assign wdata = {bus.avm_readdata[7:0], bus.avm_readdata[15:8],
                   bus.avm_readdata[23:16], bus.avm_readdata[31:24]};
`else
   assign wdata = bus.avm_readdata;
`endif

   always_comb begin
      outs_next = outs_reg;
      if (accept && !push)
         outs_next = outs_reg + 1'b1;
      else if (push && !accept)
         outs_next = outs_reg - 1'b1;

      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + 1'b1;
      else if (pop && !push)
         count_next = count_reg - 1'b1;

      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_ok) state_next = READ;
         READ:    if (last_read) state_next = DRAIN;
         DRAIN:   if (pop && is_eop) state_next = IDLE;
         default: state_next = IDLE;
      endcase

      // A stalled request stays up; a new one needs a free buffer slot
      // counting both buffered words and reads still in flight.
      if (rd_reg && !accept)
         rd_next = 1'b1;
      else
         rd_next = (state_next == READ) &&
                   (({1'b0, count_next} + {1'b0, outs_next}) < DEPTH_C);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         addr_reg       <= '0;
         rd_reg         <= 1'b0;
         reads_left_reg <= '0;
         len_reg        <= '0;
         pop_idx_reg    <= '0;
         outs_reg       <= '0;
         count_reg      <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         done_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         rd_reg    <= rd_next;
         outs_reg  <= outs_next;
         count_reg <= count_next;
         done_reg  <= start_zero | ((state_reg == DRAIN) & pop & is_eop);
         if (start_ok) begin
            addr_reg       <= base_addr;
            len_reg        <= length;
            reads_left_reg <= length;
            pop_idx_reg    <= '0;
         end else begin
            if (accept) begin
               addr_reg       <= addr_reg + 12'd1;
               reads_left_reg <= reads_left_reg - 13'd1;
            end
            if (pop)
               pop_idx_reg <= pop_idx_reg + 13'd1;
         end
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= wdata;
   end

   assign bus.avm_address = addr_reg;
   assign bus.avm_read    = rd_reg;
   assign bus.src_valid   = (count_reg != '0);
   assign bus.src_data    = mem[rd_ptr_reg];
   assign bus.src_sop     = (count_reg != '0) & (pop_idx_reg == 13'd0);
   assign bus.src_eop     = (count_reg != '0) & is_eop;
   assign busy            = (state_reg != IDLE) | done_reg;
   assign done            = done_reg;
endmodule

// File: tb/tb_onchip_stream_reader.sv
// Randomised bench for onchip_stream_reader: a memory/sink model with random stalls,
// latencies and backpressure, checked against the expected word stream mem[base+i].
module tb_onchip_stream_reader;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start = 1'b0;
   logic [11:0] base_addr = '0;
   logic [12:0] length = '0;
   logic        busy, done;

   onchip_stream_reader_if bus();

   onchip_stream_reader #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
      .length(length), .busy(busy), .done(done), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   logic [31:0] smem [4096];

   function automatic logic [31:0] exp_word(input logic [11:0] a);
      logic [31:0] w;
      w = smem[a];
`ifdef ONCHIP_STREAM_READER_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   typedef struct {
      logic [11:0] addr;
      int          due;
   } rsp_t;
   rsp_t rspq[$];

   // environment knobs
   int wr_prob = 0, lat_min = 1, lat_max = 1, rdy_prob = 100;
   bit rdy_force_low = 1'b0;
   int stall_at = -1, stall_len = 0, stall_cnt = 0;

   // reference model of the current transfer
   logic [11:0] xf_base = '0, exp_addr = '0, pend_addr = '0;
   int xf_len = 0, acc_cnt = 0, pop_cnt = 0, done_cnt = 0;
   int tb_outs = 0, tb_fifo = 0, eop_cyc = -10, rd_cycles = 0, valid_cycles = 0;
   int cyc = 0;
   bit pend = 1'b0;

   initial begin : env
      logic cur_rdv, cur_wr, cur_rdy;
      rsp_t rsp, tmp;
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      bus.src_ready         = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         cur_rdv = 1'b0;
         rsp.addr = '0;
         rsp.due  = 0;
         if (rspq.size() > 0 && rspq[0].due <= cyc) begin
            cur_rdv = 1'b1;
            rsp = rspq.pop_front();
         end
         if (!reset_n) begin
            tb_outs = 0;
            tb_fifo = 0;
            pend    = 1'b0;
            bus.avm_waitrequest   = 1'b0;
            bus.avm_readdatavalid = cur_rdv;
            bus.avm_readdata      = smem[rsp.addr];
            bus.src_ready         = 1'b0;
            continue;
         end
         if (pend) begin
            check_val("hold_read", 32'(bus.avm_read), 32'd1);
            check_val("hold_addr", 32'(bus.avm_address), 32'(pend_addr));
         end
         check_val("src_valid", 32'(bus.src_valid), 32'(tb_fifo != 0));
         if (bus.avm_read)
            check_val("credit", 32'((tb_outs + tb_fifo) < DEPTH), 32'd1);

         if (bus.avm_read && stall_at == acc_cnt && stall_cnt < stall_len) begin
            cur_wr = 1'b1;
            stall_cnt++;
         end else begin
            cur_wr = (int'($urandom_range(99)) < wr_prob);
         end
         cur_rdy = !rdy_force_low && (int'($urandom_range(99)) < rdy_prob);

         if (cur_rdv && tb_outs > 0) begin
            tb_outs--;
            tb_fifo++;
         end
         if (bus.avm_read && !cur_wr) begin
            check_val("extra_read", 32'(acc_cnt < xf_len), 32'd1);
            check_val("avm_addr", 32'(bus.avm_address), 32'(exp_addr));
            exp_addr = exp_addr + 12'd1;
            acc_cnt++;
            tb_outs++;
            tmp.addr = bus.avm_address;
            tmp.due  = cyc + int'($urandom_range(lat_max, lat_min));
            rspq.push_back(tmp);
            pend = 1'b0;
         end else begin
            pend      = bus.avm_read;
            pend_addr = bus.avm_address;
         end
         if (bus.src_valid && cur_rdy) begin
            check_val("word_count", 32'(pop_cnt < xf_len), 32'd1);
            check_val("src_data", bus.src_data, exp_word(xf_base + 12'(pop_cnt)));
            check_val("src_sop", 32'(bus.src_sop), 32'(pop_cnt == 0));
            check_val("src_eop", 32'(bus.src_eop), 32'(pop_cnt == xf_len - 1));
            if (pop_cnt == xf_len - 1)
               eop_cyc = cyc;
            pop_cnt++;
            if (tb_fifo > 0)
               tb_fifo--;
         end
         if (bus.avm_read)
            rd_cycles++;
         if (bus.src_valid)
            valid_cycles++;
         if (done) begin
            done_cnt++;
            check_val("busy_at_done", 32'(busy), 32'd1);
            if (xf_len > 0)
               check_val("done_after_eop", 32'(cyc), 32'(eop_cyc + 1));
         end
         bus.avm_waitrequest   = cur_wr;
         bus.avm_readdatavalid = cur_rdv;
         bus.avm_readdata      = cur_rdv ? smem[rsp.addr] : $urandom;
         bus.src_ready         = cur_rdy;
      end
   end

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
      check_val({tag, "_done"}, 32'(done), 32'd0);
      check_val({tag, "_avm_read"}, 32'(bus.avm_read), 32'd0);
      check_val({tag, "_avm_address"}, 32'(bus.avm_address), 32'd0);
      check_val({tag, "_src_valid"}, 32'(bus.src_valid), 32'd0);
      check_val({tag, "_src_sop"}, 32'(bus.src_sop), 32'd0);
      check_val({tag, "_src_eop"}, 32'(bus.src_eop), 32'd0);
   endtask

   task automatic begin_xfer(input logic [11:0] b, input int len);
      @(negedge clk);
      xf_base = b;      xf_len = len;     exp_addr = b;
      pop_cnt = 0;      acc_cnt = 0;      stall_cnt = 0;
      done_cnt = 0;     rd_cycles = 0;    valid_cycles = 0;
      eop_cyc = -10;
      start = 1'b1;
      base_addr = b;
      length = 13'(len);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_xfer(input logic [11:0] b, input int len, input bit noise, input bit hold_sink);
      bit got;
      int limit;
      rdy_force_low = hold_sink;
      begin_xfer(b, len);
      if (len == 0) begin
         check_val("zero_len_done", 32'(done), 32'd1);
      end else begin
         check_val("busy_after_start", 32'(busy), 32'd1);
         check_val("no_early_done", 32'(done), 32'd0);
      end
      if (hold_sink) begin
         repeat (30) @(negedge clk);
         check_val("held_reads", 32'(acc_cnt), 32'(DEPTH));
         check_val("held_avm_read", 32'(bus.avm_read), 32'd0);
         rdy_force_low = 1'b0;
      end
      got = 1'b0;
      limit = 200 * len + 200;
      for (int n = 0; n < limit; n++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         start = noise && ($urandom_range(9) == 0);
         base_addr = 12'($urandom);
         length = 13'($urandom_range(4096));
         @(negedge clk);
      end
      start = 1'b0;
      check_val("done_seen", 32'(got), 32'd1);
      check_val("busy_with_done", 32'(busy), 32'(got));
      @(negedge clk);
      check_val("busy_drop", 32'(busy), 32'd0);
      check_val("done_pulse_1cyc", 32'(done), 32'd0);
      check_val("words", 32'(pop_cnt), 32'(len));
      check_val("reads", 32'(acc_cnt), 32'(len));
      check_val("done_pulses", 32'(done_cnt), 32'd1);
      if (len == 0) begin
         check_val("zero_len_no_read", 32'(rd_cycles), 32'd0);
         check_val("zero_len_no_valid", 32'(valid_cycles), 32'd0);
      end
      $display("xfer base=0x%03h len=%0d reads=%0d words=%0d done=%0d",
               b, len, acc_cnt, pop_cnt, got);
   endtask

   task automatic set_env(input int wp, input int lmin, input int lmax, input int rp);
      wr_prob = wp;  lat_min = lmin;  lat_max = lmax;  rdy_prob = rp;
   endtask

   initial begin : main
      int len;
      bit drained;
      for (int i = 0; i < 4096; i++)
         smem[i] = $urandom;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1 check_idle_outputs("reset");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      set_env(0, 1, 1, 100);
      do_xfer(12'h010, 3, 1'b0, 1'b0);
      do_xfer(12'hFFE, 4, 1'b0, 1'b0);
      do_xfer(12'h123, 8, 1'b0, 1'b1);

      stall_at = 1;
      stall_len = 3;
      do_xfer(12'h200, 5, 1'b0, 1'b0);
      check_val("stall_cycles", 32'(stall_cnt), 32'd3);
      stall_at = -1;

      do_xfer(12'h055, 0, 1'b0, 1'b0);
      do_xfer(12'h7FF, 1, 1'b0, 1'b0);

      // abort with reads in flight, then a clean short transfer
      set_env(0, 3, 3, 100);
      begin_xfer(12'h300, 16);
      for (int k = 0; k < 50; k++) begin
         if (tb_outs >= 2)
            break;
         @(negedge clk);
      end
      check_val("outs_before_abort", 32'(tb_outs >= 2), 32'd1);
      reset_n = 1'b0;
      #1 check_idle_outputs("abort");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      drained = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (rspq.size() == 0) begin
            drained = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_val("late_rsp_drained", 32'(drained), 32'd1);
      repeat (2) @(negedge clk);
      check_val("post_abort_valid", 32'(bus.src_valid), 32'd0);
      check_val("post_abort_busy", 32'(busy), 32'd0);
      set_env(0, 1, 1, 100);
      do_xfer(12'h345, 2, 1'b0, 1'b0);

      for (int t = 0; t < 12; t++) begin
         set_env(int'($urandom_range(50)), 1, int'($urandom_range(4, 1)),
                 int'($urandom_range(100, 30)));
         len = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(40, 1));
         do_xfer(12'($urandom), len, 1'b1, 1'b0);
      end

      set_env(0, 1, 1, 100);
      do_xfer(12'h800, 4096, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
